warp_scheduler: RTL
===================

// Module: warp_scheduler
// PURPOSE
//  Multi-warp successor to the per-block active-thread mask logic. Launches up to
//  NUM_WARPS warps of THREADS_PER_WARP threads from a thread count and holds a live
//  mask per warp. Issues ready warps to the core round-robin over a valid/ready
//  handshake. Narrows masks on retire (divergence/exit) and flags block completion.
// PARAMETERS
//  NUM_WARPS         4  warps per block (>=2)
//  THREADS_PER_WARP  4  threads per warp = mask width
//  WID_W = $clog2(NUM_WARPS) (localparam); TC_W = $clog2(NUM_WARPS*THREADS_PER_WARP)+1
// PORTS
//  clk           in   1                 clock, rising edge
//  reset         in   1                 asynchronous, active-high
//  start         in   1                 launch pulse, sampled when not busy
//  thread_count  in   TC_W              threads in block; values > NUM_WARPS*TPW clip
//  issue_valid   out  1                 issue slot holds a warp
//  issue_ready   in   1                 core accepts issue slot
//  issue_warp    out  WID_W             warp id in issue slot
//  issue_mask    out  THREADS_PER_WARP  live thread mask of that warp
//  retire_valid  in   1                 core returns an in-flight warp
//  retire_warp   in   WID_W             warp id being returned
//  retire_mask   in   THREADS_PER_WARP  threads still live after this pass
//  busy          out  1                 block running
//  done          out  1                 all warps exited; held until next start
//  err           out  1                 sticky: illegal retire seen; cleared by start
// BEHAVIOUR
//  Reset (async): all outputs 0, all warps INACTIVE, rr pointer 0, FSM IDLE.
//  Top FSM IDLE -> RUN -> DONE. start ignored in RUN. start in IDLE/DONE relaunches.
//  Launch (start while !busy): next edge sets busy=1, done=0, err=0, rr=0.
//   Warp w gets mask[t] = (w*TPW+t < thread_count). Any bit set -> READY, else INACTIVE.
//   If thread_count==0, go to DONE next edge: busy=0, done=1, no issue.
//  Per-warp states: INACTIVE, READY, IN_FLIGHT, EXITED.
//  Issue slot is registered. When slot is empty or handshakes this cycle, the next
//   edge loads the first READY warp at or after rr, wrapping modulo NUM_WARPS.
//   That warp goes READY->IN_FLIGHT on load. issue_valid=1 if one was found, else 0.
//   Handshake = issue_valid & issue_ready. On handshake rr <= issue_warp+1 (wraps).
//   issue_warp/issue_mask stay stable while issue_valid & !issue_ready.
//   Latency: warp becomes READY at edge N -> issue_valid at edge N+1 earliest.
//  Retire (retire_valid): legal only if retire_warp is IN_FLIGHT and not the one in
//   the issue slot awaiting handshake.
//   new = mask & retire_mask. new!=0 -> mask<=new, READY. new==0 -> EXITED.
//   Illegal retire: no state change, err<=1.
//   Retire and issue load in the same cycle: the retired warp is not a load
//   candidate until the next cycle.
//  Completion: when every non-INACTIVE warp is EXITED and the issue slot is empty,
//   next edge: busy=0, done=1, FSM DONE.
//  Reset mid-run aborts immediately; no completion is reported.
//  Inputs are ignored when FSM is not RUN, except start.
// TESTING
//  1 thread_count=10, start; core always ready, retire each warp with mask 0 ->
//    issues w0 m1111, w1 m1111, w2 m0011, in order. w3 never issued; done=1 after
//    3 retires.
//  2 thread_count=16, issue_ready=0 for 5 cycles -> issue_valid=1, warp 0, mask 1111
//    stable all 5 cycles; w0 then w1 issued after ready rises.
//  3 Divergence: retire w0 with retire_mask=0101 -> w0 reissued later with mask 0101;
//    retire with 0100 -> mask 0100; retire with 0000 -> EXITED.
//  4 Round-robin: 4 warps; w1 retired non-exiting while w3 is issued -> next issue
//    order w0, w1, not w1 first.
//  5 thread_count=0 -> done=1 one cycle after start, issue_valid never 1.
//    thread_count=31 -> clipped, behaves as 16.
//  6 Retire of an INACTIVE warp -> err=1, masks unchanged. Assert reset mid-run ->
//    all outputs 0 asynchronously. Next start clears err.

Source files
------------

// File: rtl/warp_scheduler.sv
// Multi-warp launch/issue/retire scheduler: builds per-warp live masks from a thread
// count, issues READY warps round-robin over valid/ready and narrows masks on retire.
module warp_scheduler #(
  parameter int unsigned NUM_WARPS        = 4,
  parameter int unsigned THREADS_PER_WARP = 4,
  localparam int unsigned WID_W = $clog2(NUM_WARPS),
  localparam int unsigned TC_W  = $clog2(NUM_WARPS * THREADS_PER_WARP) + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [TC_W-1:0]             thread_count,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [WID_W-1:0]            issue_warp,
  output logic [THREADS_PER_WARP-1:0] issue_mask,
  input  logic                        retire_valid,
  input  logic [WID_W-1:0]            retire_warp,
  input  logic [THREADS_PER_WARP-1:0] retire_mask,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int unsigned TB_W = (THREADS_PER_WARP > 1) ? $clog2(THREADS_PER_WARP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_e;
  typedef enum logic [1:0] {W_INACTIVE, W_READY, W_IN_FLIGHT, W_EXITED} wstate_e;

  fsm_e                        state_q, state_d;
  wstate_e                     ws_q [NUM_WARPS];
  wstate_e                     ws_d [NUM_WARPS];
  logic [THREADS_PER_WARP-1:0] mask_q [NUM_WARPS];
  logic [THREADS_PER_WARP-1:0] mask_d [NUM_WARPS];
  logic [WID_W-1:0]            rr_q, rr_d;
  logic                        issue_valid_q, issue_valid_d;
  logic [WID_W-1:0]            issue_warp_q, issue_warp_d;
  logic [THREADS_PER_WARP-1:0] issue_mask_q, issue_mask_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;

  logic                        hs;
  logic                        ret_ok;
  logic [THREADS_PER_WARP-1:0] new_mask;
  logic                        found;
  logic [WID_W-1:0]            sel;
  int unsigned                 idx;
  logic                        all_exit;

  always_comb begin
    state_d       = state_q;
    ws_d          = ws_q;
    mask_d        = mask_q;
    rr_d          = rr_q;
    issue_valid_d = issue_valid_q;
    issue_warp_d  = issue_warp_q;
    issue_mask_d  = issue_mask_q;
    busy_d        = busy_q;
    done_d        = done_q;
    err_d         = err_q;
    hs            = issue_valid_q & issue_ready;
    ret_ok        = 1'b0;
    new_mask      = '0;
    found         = 1'b0;
    sel           = '0;
    idx           = 0;
    all_exit      = 1'b1;

    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      if (ws_q[WID_W'(w)] == W_READY || ws_q[WID_W'(w)] == W_IN_FLIGHT) all_exit = 1'b0;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Thread t of warp w is live when its global index is below the count.
          for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            for (int unsigned t = 0; t < THREADS_PER_WARP; t++) begin
              mask_d[WID_W'(w)][TB_W'(t)] = ((w * THREADS_PER_WARP + t) < 32'(thread_count));
            end
            ws_d[WID_W'(w)] = (mask_d[WID_W'(w)] != '0) ? W_READY : W_INACTIVE;
          end
          rr_d          = '0;
          issue_valid_d = 1'b0;
          err_d         = 1'b0;
          if (thread_count == '0) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
      end

      S_RUN: begin
        // A warp held in the slot awaiting handshake cannot be returned yet.
        if (retire_valid) begin
          ret_ok = (ws_q[retire_warp] == W_IN_FLIGHT) &&
                   !(issue_valid_q && (issue_warp_q == retire_warp));
          if (ret_ok) begin
            new_mask = mask_q[retire_warp] & retire_mask;
            if (new_mask != '0) begin
              mask_d[retire_warp] = new_mask;
              ws_d[retire_warp]   = W_READY;
            end else begin
              ws_d[retire_warp]   = W_EXITED;
            end
          end else begin
            err_d = 1'b1;
          end
        end

        // Candidates come from registered state, so a warp retired this cycle waits.
        if (!issue_valid_q || hs) begin
          if (hs) rr_d = WID_W'((32'(issue_warp_q) + 1) % NUM_WARPS);
          for (int unsigned k = 0; k < NUM_WARPS; k++) begin
            idx = (32'(rr_d) + k) % NUM_WARPS;
            if (!found && ws_q[WID_W'(idx)] == W_READY) begin
              found = 1'b1;
              sel   = WID_W'(idx);
            end
          end
          issue_valid_d = found;
          if (found) begin
            issue_warp_d = sel;
            issue_mask_d = mask_q[sel];
            ws_d[sel]    = W_IN_FLIGHT;
          end
        end

        if (all_exit && !issue_valid_q) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ws_q          <= '{default: W_INACTIVE};
      mask_q        <= '{default: '0};
      rr_q          <= '0;
      issue_valid_q <= 1'b0;
      issue_warp_q  <= '0;
      issue_mask_q  <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      ws_q          <= ws_d;
      mask_q        <= mask_d;
      rr_q          <= rr_d;
      issue_valid_q <= issue_valid_d;
      issue_warp_q  <= issue_warp_d;
      issue_mask_q  <= issue_mask_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_warp  = issue_warp_q;
  assign issue_mask  = issue_mask_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
